// File: rtl/l1_snoop_ctrl_if.sv
// Snoop port bundle: SCU snoop handshake, L1 tag-port borrow/read/invalidate
// signals and the snoop statistics counters.
`ifndef CACHE_ADDR_WIDTH
`define CACHE_ADDR_WIDTH 32
`endif

interface l1_snoop_ctrl_if #(
  parameter int unsigned ADDR_W   = `CACHE_ADDR_WIDTH,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFFSET_W;

  logic [ADDR_W-1:0]       snp_addr;
  logic                    snp_valid;
  logic                    snp_ready;
  logic                    tag_req;
  logic                    tag_gnt;
  logic                    tag_rd_en;
  logic [IDX_W-1:0]        tag_idx;
  logic [WAYS*TAG_W-1:0]   tag_rd_tag;
  logic [WAYS-1:0]         tag_rd_vld;
  logic                    inv_en;
  logic [WAYS-1:0]         inv_way;
  logic [CNT_W-1:0]        snp_cnt;
  logic [CNT_W-1:0]        hit_cnt;

  // Snoop consumer side
  modport slave (
    input  snp_addr, snp_valid, tag_gnt, tag_rd_tag, tag_rd_vld,
    output snp_ready, tag_req, tag_rd_en, tag_idx, inv_en, inv_way, snp_cnt, hit_cnt
  );

  // SCU / arbiter / tag array side
  modport master (
    output snp_addr, snp_valid, tag_gnt, tag_rd_tag, tag_rd_vld,
    input  snp_ready, tag_req, tag_rd_en, tag_idx, inv_en, inv_way, snp_cnt, hit_cnt
  );
endinterface

// File: rtl/l1_snoop_ctrl.sv
// Per-core snoop consumer: borrows the L1 tag port, looks up the snooped set and
// invalidates every valid way whose stored tag matches; counts snoops and hits.
`ifndef CACHE_ADDR_WIDTH
`define CACHE_ADDR_WIDTH 32
`endif

module l1_snoop_ctrl #(
  parameter int unsigned ADDR_W   = `CACHE_ADDR_WIDTH,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rstn,
  l1_snoop_ctrl_if.slave bus
);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CMP  = 2'd2,
    S_INV  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                rdy_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAYS-1:0]     hit_q, hit_d;
  logic [CNT_W-1:0]    snp_cnt_q, snp_cnt_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;

  logic [IDX_W-1:0]    idx_c;
  logic [TAG_W-1:0]    tag_c;
  logic [WAYS-1:0]     hit_c;
  logic                snp_ready_c;
  logic                tag_req_c;
  logic                tag_rd_en_c;
  logic                inv_en_c;
  logic [WAYS-1:0]     inv_way_c;
  logic [IDX_W-1:0]    tag_idx_c;
  logic                unused_offset;

  assign idx_c         = addr_q[OFFSET_W +: IDX_W];
  assign tag_c         = addr_q[ADDR_W-1 -: TAG_W];
  // Line offset is latched with the address but has no role in a set lookup
  assign unused_offset = ^addr_q[OFFSET_W-1:0];

  // Per-way match against the tag read launched in REQ
  always_comb begin : hit_compare
    hit_c = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_c[w] = bus.tag_rd_vld[w] && (bus.tag_rd_tag[w*TAG_W +: TAG_W] == tag_c);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : state_reg
    if (!rstn) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      hit_q     <= '0;
      snp_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      addr_q    <= addr_d;
      hit_q     <= hit_d;
      snp_cnt_q <= snp_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    addr_d      = addr_q;
    hit_d       = hit_q;
    snp_cnt_d   = snp_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    snp_ready_c = 1'b0;
    tag_req_c   = 1'b0;
    tag_rd_en_c = 1'b0;
    inv_en_c    = 1'b0;
    inv_way_c   = '0;
    tag_idx_c   = '0;

    case (state_q)
      S_IDLE: begin
        snp_ready_c = rdy_q;
        if (rdy_q && bus.snp_valid) begin
          addr_d  = bus.snp_addr;
          state_d = S_REQ;
          if (snp_cnt_q != '1) begin
            snp_cnt_d = snp_cnt_q + CNT_W'(1);
          end
        end
      end
      S_REQ: begin
        tag_req_c = 1'b1;
        // Read launches in the grant cycle; data arrives while in CMP
        if (bus.tag_gnt) begin
          tag_rd_en_c = 1'b1;
          tag_idx_c   = idx_c;
          state_d     = S_CMP;
        end
      end
      S_CMP: begin
        tag_req_c = 1'b1;
        if (|hit_c) begin
          hit_d   = hit_c;
          state_d = S_INV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INV: begin
        tag_req_c = 1'b1;
        inv_en_c  = 1'b1;
        inv_way_c = hit_q;
        tag_idx_c = idx_c;
        hit_d     = '0;
        state_d   = S_IDLE;
        if (hit_cnt_q != '1) begin
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.snp_ready = snp_ready_c;
  assign bus.tag_req   = tag_req_c;
  assign bus.tag_rd_en = tag_rd_en_c;
  assign bus.tag_idx   = tag_idx_c;
  assign bus.inv_en    = inv_en_c;
  assign bus.inv_way   = inv_way_c;
  assign bus.snp_cnt   = snp_cnt_q;
  assign bus.hit_cnt   = hit_cnt_q;

  // Arbiter contract: grant, once given, is held for the rest of the borrow
  gnt_held_a : assert property (@(posedge clk) disable iff (!rstn)
    (state_q == S_CMP || state_q == S_INV) |-> bus.tag_gnt);

  strobe_needs_gnt_a : assert property (@(posedge clk) disable iff (!rstn)
    (bus.tag_rd_en || bus.inv_en) |-> bus.tag_gnt);

  inv_single_cycle_a : assert property (@(posedge clk) disable iff (!rstn)
    bus.inv_en |=> !bus.inv_en);

  req_held_a : assert property (@(posedge clk) disable iff (!rstn)
    (bus.tag_req && state_d != S_IDLE) |=> bus.tag_req);

endmodule

// File: tb/tb_l1_snoop_ctrl.sv
// Bench for l1_snoop_ctrl: table-driven snoops with a scoreboard of expected
// invalidate masks, indices and latencies, plus reset/burst/saturation sequences.
module tb_l1_snoop_ctrl;
  localparam int unsigned TAG_W = 22;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] snp_addr;
  logic        snp_valid;
  logic [43:0] rd_tag;
  logic [1:0]  rd_vld;
  logic        gnt;
  int          gdly;
  int          wc;
  bit          mon_en;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_snp = 0;
  int exp_hit = 0;

  typedef struct {
    logic [5:0] idx;
    logic [1:0] mask;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0]      addr;
    logic [TAG_W-1:0] t0;
    logic [TAG_W-1:0] t1;
    logic [1:0]       vld;
    int               gdly;
    logic [1:0]       mask;
    logic [5:0]       idx;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  l1_snoop_ctrl_if #(.CNT_W(16)) if16 ();
  l1_snoop_ctrl_if #(.CNT_W(2))  if2 ();

  l1_snoop_ctrl #(.CNT_W(16)) dut (.clk(clk), .rstn(rstn), .bus(if16));
  l1_snoop_ctrl #(.CNT_W(2))  dut_sat (.clk(clk), .rstn(rstn), .bus(if2));

  // Arbiter model: grant after gdly cycles of request, held while requested
  assign gnt = if16.tag_req && (wc >= gdly);
  always @(posedge clk or negedge rstn) begin
    if (!rstn)                 wc <= 0;
    else if (!if16.tag_req)    wc <= 0;
    else if (!gnt)             wc <= wc + 1;
  end

  assign if16.snp_addr   = snp_addr;
  assign if16.snp_valid  = snp_valid;
  assign if16.tag_gnt    = gnt;
  assign if16.tag_rd_tag = rd_tag;
  assign if16.tag_rd_vld = rd_vld;
  assign if2.snp_addr    = snp_addr;
  assign if2.snp_valid   = snp_valid;
  assign if2.tag_gnt     = gnt;
  assign if2.tag_rd_tag  = rd_tag;
  assign if2.tag_rd_vld  = rd_vld;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  // Monitor / scoreboard consumer
  bit         busy = 1'b0;
  int         cyc;
  int         n_inv;
  logic [1:0] obs_mask;
  logic [5:0] obs_idx;

  always @(negedge clk) begin
    exp_t e;
    if (!rstn || !mon_en) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        cyc++;
        if (if16.snp_ready) begin
          busy = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("inv_mask", 32'(obs_mask), 32'(e.mask));
            chk("inv_pulses", 32'(n_inv), (e.mask != 2'b00) ? 32'd1 : 32'd0);
            chk("rd_idx", 32'(obs_idx), 32'(e.idx));
            chk("latency", 32'(cyc), 32'(e.lat));
          end
        end else begin
          chk("tag_req_held", 32'(if16.tag_req), 32'd1);
          if (if16.tag_rd_en) begin
            chk("rd_en_gnt", 32'(gnt), 32'd1);
            obs_idx = if16.tag_idx;
          end
          if (if16.inv_en) begin
            chk("inv_en_gnt", 32'(gnt), 32'd1);
            obs_mask = obs_mask | if16.inv_way;
            n_inv++;
            if (exp_q.size() != 0) chk("inv_idx", 32'(if16.tag_idx), 32'(exp_q[0].idx));
          end
          if (!if16.tag_rd_en && !if16.inv_en)
            chk("quiet_bus", 32'({if16.inv_way, if16.tag_idx}), 32'd0);
        end
      end
      if (!busy) begin
        chk("idle_bus", 32'({if16.tag_req, if16.tag_rd_en, if16.inv_en, if16.inv_way, if16.tag_idx}), 32'd0);
        if (snp_valid && if16.snp_ready) begin
          busy     = 1'b1;
          cyc      = 0;
          n_inv    = 0;
          obs_mask = 2'b00;
          obs_idx  = 6'd0;
        end
      end
    end
  end

  task automatic set_way(input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                         input logic [1:0] v, input int d);
    rd_tag = {t1, t0};
    rd_vld = v;
    gdly   = d;
  endtask

  task automatic push_exp(input logic [5:0] idx, input logic [1:0] m, input int d);
    exp_t e;
    e.idx  = idx;
    e.mask = m;
    e.lat  = ((m != 2'b00) ? 4 : 3) + d;
    exp_q.push_back(e);
    exp_snp++;
    if (m != 2'b00) exp_hit++;
  endtask

  task automatic wait_ready(input string what);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (if16.snp_ready) seen = 1'b1;
    end
    if (!seen) chk({what, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk("completion_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [5:0] idx, input logic [1:0] m, input int d);
    @(posedge clk);
    #1;
    snp_addr  = a;
    snp_valid = 1'b1;
    push_exp(idx, m, d);
    wait_ready("accept");
    @(posedge clk);
    #1;
    snp_valid = 1'b0;
    snp_addr  = 32'hDEAD_BEEF;
    wait_done();
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    chk({tag, "_snp_cnt"}, 32'(if16.snp_cnt), 32'(exp_snp));
    chk({tag, "_hit_cnt"}, 32'(if16.hit_cnt), 32'(exp_hit));
    chk({tag, "_snp_cnt_sat"}, 32'(if2.snp_cnt), 32'(sat3(exp_snp)));
    chk({tag, "_hit_cnt_sat"}, 32'(if2.hit_cnt), 32'(sat3(exp_hit)));
  endtask

  logic [31:0] burst_addr[4];
  logic [5:0]  burst_idx[4];
  logic [1:0]  burst_mask[4];

  initial begin
    vecs[0] = '{addr: 32'h8000_1230, t0: 22'h000000, t1: 22'h200004, vld: 2'b10, gdly: 0, mask: 2'b10, idx: 6'h23};
    vecs[1] = '{addr: 32'h8000_1230, t0: 22'h200005, t1: 22'h200005, vld: 2'b11, gdly: 0, mask: 2'b00, idx: 6'h23};
    vecs[2] = '{addr: 32'h8000_1230, t0: 22'h200004, t1: 22'h200005, vld: 2'b10, gdly: 0, mask: 2'b00, idx: 6'h23};
    vecs[3] = '{addr: 32'h8000_1230, t0: 22'h000000, t1: 22'h200004, vld: 2'b11, gdly: 5, mask: 2'b10, idx: 6'h23};
    vecs[4] = '{addr: 32'h0000_0000, t0: 22'h000000, t1: 22'h000000, vld: 2'b01, gdly: 0, mask: 2'b01, idx: 6'h00};
    vecs[5] = '{addr: 32'h1234_5678, t0: 22'h048D15, t1: 22'h048D15, vld: 2'b11, gdly: 0, mask: 2'b11, idx: 6'h27};

    burst_addr = '{32'h0000_0400, 32'hFFFF_FFFF, 32'h0000_07F5, 32'hFFFF_FC00};
    burst_idx  = '{6'h00, 6'h3F, 6'h3F, 6'h00};
    burst_mask = '{2'b01, 2'b10, 2'b01, 2'b10};

    mon_en    = 1'b0;
    snp_valid = 1'b0;
    snp_addr  = 32'h0;
    set_way(22'h0, 22'h0, 2'b00, 0);

    // Reset values, then ready one cycle after release
    #12;
    chk("rst_outputs", 32'({if16.snp_ready, if16.tag_req, if16.tag_rd_en, if16.inv_en, if16.inv_way, if16.tag_idx}), 32'd0);
    chk("rst_snp_cnt", 32'(if16.snp_cnt), 32'd0);
    chk("rst_hit_cnt", 32'(if16.hit_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("ready_before_edge", 32'(if16.snp_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(if16.snp_ready), 32'd1);
    chk("cnt_after_release", 32'({if16.snp_cnt, if16.hit_cnt}), 32'd0);
    mon_en = 1'b1;

    foreach (vecs[k]) begin
      set_way(vecs[k].t0, vecs[k].t1, vecs[k].vld, vecs[k].gdly);
      send(vecs[k].addr, vecs[k].idx, vecs[k].mask, vecs[k].gdly);
      check_counts($sformatf("vec%0d", k));
    end

    // Clean restart, then back-to-back snoops with valid held high
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst2_counters", 32'({if16.snp_cnt, if16.hit_cnt}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    exp_snp = 0;
    exp_hit = 0;
    set_way(22'h000001, 22'h3FFFFF, 2'b11, 0);
    @(posedge clk);
    #1;
    snp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      snp_addr = burst_addr[k];
      push_exp(burst_idx[k], burst_mask[k], 0);
      wait_ready("burst_accept");
      @(posedge clk);
      #1;
    end
    snp_valid = 1'b0;
    wait_done();
    check_counts("burst");

    // Fifth hit pushes the narrow counters past saturation
    send(32'h0000_0530, 6'h13, 2'b01, 0);
    check_counts("sat");

    // Async reset while the invalidate strobe is up
    mon_en = 1'b0;
    set_way(22'h000000, 22'h200004, 2'b10, 0);
    @(posedge clk);
    #1;
    snp_addr  = 32'h8000_1230;
    snp_valid = 1'b1;
    wait_ready("rst_inv_accept");
    @(posedge clk);
    #1;
    snp_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (if16.inv_en) seen = 1'b1;
      end
      chk("inv_seen", 32'(seen), 32'd1);
    end
    chk("inv_way_pre_rst", 32'(if16.inv_way), 32'h2);
    chk("inv_idx_pre_rst", 32'(if16.tag_idx), 32'h23);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_inv_bus", 32'({if16.tag_req, if16.inv_en, if16.inv_way, if16.tag_idx, if16.snp_ready}), 32'd0);
    chk("rst_mid_inv_sat_bus", 32'({if2.tag_req, if2.inv_en}), 32'd0);
    chk("rst_mid_inv_cnt", 32'({if16.snp_cnt, if16.hit_cnt}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_rst_mid_inv", 32'(if16.snp_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
